// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: access sizes, FSM states and
// the alignment rule.
package mem_pkg;
    localparam int BYTE_LANES = 4;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {IDLE, RD, EXT, WR, RMW_RD, RMW_WR, ERR} state_e;

    // Size 3 has no legal alignment, so it always reports as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return off != 2'd0;
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge for a
// little-endian 32-bit word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[8*off +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  load_data = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SIZE_H:  load_data = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = word;
        endcase

        merged = word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (size == SIZE_B && off == i[1:0])
                merged[8*i +: 8] = wdata[7:0];
            if (size == SIZE_H && off[1] == i[1])
                merged[8*i +: 8] = wdata[8*(i%2) +: 8];
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide synchronous memory; sub-word stores use
// read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_ra,
    output logic [ADDR_WIDTH-1:0] mem_wa,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    typedef struct packed {
        logic [1:0]            size;
        logic                  uns;
        logic [1:0]            off;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_e                state_q, state_d;
    req_t                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] mem_ra_q, mem_ra_d, mem_wa_q, mem_wa_d, word_addr;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d, resp_rdata_q, resp_rdata_d;
    logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] load_data, merged;

    mem_lane_align u_align (
        .off       (req_q.off),
        .size      (req_q.size),
        .uns       (req_q.uns),
        .word      (mem_rd),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    assign word_addr = {2'b00, req_addr[ADDR_WIDTH-1:2]};

    // Every terminal state responds on the way back to IDLE; misaligned
    // requests respond straight from IDLE, so ERR is never occupied.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_ra_d     = mem_ra_q;
        mem_wa_d     = mem_wa_q;
        mem_wd_d     = mem_wd_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{size: req_size, uns: req_unsigned, off: req_addr[1:0],
                              wdata: req_wdata};
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        mem_ra_d = word_addr;
                        state_d  = RD;
                    end else if (req_size == SIZE_W) begin
                        mem_wa_d = word_addr;
                        mem_wd_d = req_wdata;
                        state_d  = WR;
                    end else begin
                        mem_ra_d = word_addr;
                        mem_wa_d = word_addr;
                        state_d  = RMW_RD;
                    end
                end
            end
            RD:     state_d = EXT;
            EXT: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = IDLE;
            end
            WR: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RMW_RD: state_d = RMW_WR;
            RMW_WR: begin
                mem_wd_d     = merged;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            mem_ra_q     <= '0;
            mem_wa_q     <= '0;
            mem_wd_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            mem_ra_q     <= mem_ra_d;
            mem_wa_q     <= mem_wa_d;
            mem_wd_q     <= mem_wd_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Write enable is decoded from state so reset removes it immediately.
    assign mem_we     = (state_q == WR) || (state_q == RMW_WR);
    assign mem_wd     = (state_q == RMW_WR) ? merged : mem_wd_q;
    assign mem_ra     = mem_ra_q;
    assign mem_wa     = mem_wa_q;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
endmodule
